// File: rtl/mem_arbiter_if.sv
// Request/response bundle between the fetch port, the load/store port, the
// shared memory and the arbiter that sits in the middle.
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic              if_req_i;
  logic [AW-1:0]     if_addr_i;
  logic              if_gnt_o;
  logic              if_rvalid_o;
  logic [DW-1:0]     if_rdata_o;

  logic              d_req_i;
  logic              d_we_i;
  logic [AW-1:0]     d_addr_i;
  logic [DW-1:0]     d_wdata_i;
  logic [DW/8-1:0]   d_be_i;
  logic              d_gnt_o;
  logic              d_rvalid_o;
  logic [DW-1:0]     d_rdata_o;

  logic              mem_en_o;
  logic              mem_we_o;
  logic [DW/8-1:0]   mem_be_o;
  logic [AW-1:0]     mem_addr_o;
  logic [DW-1:0]     mem_wdata_o;
  logic [DW-1:0]     mem_rdata_i;

  logic              busy_o;

  // Arbiter side.
  modport slave (
    input  if_req_i, if_addr_i,
    input  d_req_i, d_we_i, d_addr_i, d_wdata_i, d_be_i,
    input  mem_rdata_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o,
    output d_gnt_o, d_rvalid_o, d_rdata_o,
    output mem_en_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    output busy_o
  );

  // Requesters plus memory, i.e. everything around the arbiter.
  modport master (
    output if_req_i, if_addr_i,
    output d_req_i, d_we_i, d_addr_i, d_wdata_i, d_be_i,
    output mem_rdata_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o,
    input  d_gnt_o, d_rvalid_o, d_rdata_o,
    input  mem_en_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    input  busy_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter sharing one fixed-latency memory port between
// instruction fetch and load/store, data first with a fetch starvation guard.
module mem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);
  localparam int BW = DW / 8;
  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  if (MEM_LAT < 1) begin : g_lat_chk
    $error("mem_arbiter: MEM_LAT must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef struct packed {
    logic is_data;
    logic is_store;
  } txn_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] starve_q, starve_d;
  txn_t          txn_q, txn_d;
  logic [DW-1:0] if_rdata_q, d_rdata_q;
  logic          arb, f_win, d_win, starved;

  // Arbitration is gated by reset so no grant escapes while rst is low.
  always_comb begin
    arb     = rst && (state_q != WAIT);
    starved = (starve_q == SW'(STARVE_MAX));
    f_win   = arb && bus.if_req_i && (!bus.d_req_i || starved);
    d_win   = arb && bus.d_req_i && !f_win;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    txn_d    = txn_q;
    starve_d = starve_q;
    case (state_q)
      IDLE, RESP: begin
        state_d = IDLE;
        if (f_win || d_win) begin
          state_d        = WAIT;
          cnt_d          = CW'(MEM_LAT - 1);
          txn_d.is_data  = d_win;
          txn_d.is_store = d_win && bus.d_we_i;
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - CW'(1);
      end
      default: state_d = IDLE;
    endcase
    if (!bus.if_req_i || f_win)  starve_d = '0;
    else if (d_win && !starved)  starve_d = starve_q + SW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      starve_q <= '0;
      txn_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      txn_q    <= txn_d;
    end
  end

  // Read data is captured on the last WAIT cycle and held until the next capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else if (state_q == WAIT && cnt_q == '0) begin
      if (txn_q.is_data) d_rdata_q  <= txn_q.is_store ? '0 : bus.mem_rdata_i;
      else               if_rdata_q <= bus.mem_rdata_i;
    end
  end

  assign bus.if_gnt_o    = f_win;
  assign bus.d_gnt_o     = d_win;
  assign bus.mem_en_o    = f_win | d_win;
  assign bus.mem_we_o    = d_win & bus.d_we_i;
  assign bus.mem_be_o    = (d_win & bus.d_we_i) ? bus.d_be_i :
                           (f_win | d_win)      ? {BW{1'b1}} : '0;
  assign bus.mem_addr_o  = d_win ? bus.d_addr_i : f_win ? bus.if_addr_i : '0;
  assign bus.mem_wdata_o = (d_win & bus.d_we_i) ? bus.d_wdata_i : '0;

  assign bus.if_rvalid_o = (state_q == RESP) && !txn_q.is_data;
  assign bus.d_rvalid_o  = (state_q == RESP) &&  txn_q.is_data;
  assign bus.if_rdata_o  = if_rdata_q;
  assign bus.d_rdata_o   = d_rdata_q;
  assign bus.busy_o      = (state_q != IDLE);
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios on MEM_LAT=2 and MEM_LAT=1
// instances plus a randomized run against a cycle-arithmetic reference model.
module tb_mem_arbiter;
  localparam int AW = 32, DW = 32, SM = 4, LAT = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(AW), .DW(DW)) ba ();
  mem_arbiter_if #(.AW(AW), .DW(DW)) bb ();

  mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT), .STARVE_MAX(SM)) dut_a (
    .clk(clk), .rst(rst), .bus(ba));
  mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(1), .STARVE_MAX(SM)) dut_b (
    .clk(clk), .rst(rst), .bus(bb));

  int n_chk = 0;
  int n_fail = 0;

  // Inputs are driven 2 time units after the rising edge, outputs sampled at +5.
  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    ba.if_req_i = 0; ba.if_addr_i = '0; ba.d_req_i = 0; ba.d_we_i = 0;
    ba.d_addr_i = '0; ba.d_wdata_i = '0; ba.d_be_i = '0; ba.mem_rdata_i = '0;
    bb.if_req_i = 0; bb.if_addr_i = '0; bb.d_req_i = 0; bb.d_we_i = 0;
    bb.d_addr_i = '0; bb.d_wdata_i = '0; bb.d_be_i = '0; bb.mem_rdata_i = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 0;
    ba.if_req_i = 1; ba.d_req_i = 1; ba.d_we_i = 1; ba.d_be_i = 4'hF;
    bb.if_req_i = 1; bb.d_req_i = 1;
    for (int i = 0; i < 3; i++) begin
      #3;
      n_chk++;
      if ({ba.if_gnt_o, ba.d_gnt_o, ba.mem_en_o, ba.mem_we_o, ba.busy_o,
           ba.if_rvalid_o, ba.d_rvalid_o, ba.mem_be_o} !== 11'b0) begin
        n_fail++;
        $display("FAIL reset_ctl_a: got %b required 0", {ba.if_gnt_o, ba.d_gnt_o,
                 ba.mem_en_o, ba.mem_we_o, ba.busy_o, ba.if_rvalid_o, ba.d_rvalid_o, ba.mem_be_o});
      end
      n_chk++;
      if ({ba.if_rdata_o, ba.d_rdata_o, bb.if_gnt_o, bb.d_gnt_o, bb.mem_en_o, bb.busy_o} !== '0) begin
        n_fail++;
        $display("FAIL reset_data: if_rdata %h d_rdata %h b_ctl %b required 0", ba.if_rdata_o,
                 ba.d_rdata_o, {bb.if_gnt_o, bb.d_gnt_o, bb.mem_en_o, bb.busy_o});
      end
      nxt();
    end
    clear_inputs();
    nxt();
    rst = 1;
    nxt();
  endtask

  task automatic test_single_fetch();
    nxt(); ba.if_req_i = 1; ba.if_addr_i = 32'h100; ba.mem_rdata_i = 32'h0BAD_F00D; #3;
    n_chk++;
    if ({ba.if_gnt_o, ba.d_gnt_o, ba.mem_en_o, ba.mem_we_o, ba.busy_o, ba.mem_be_o} !== 9'b10100_1111
        || ba.mem_addr_o !== 32'h100) begin
      n_fail++;
      $display("FAIL fetch_grant: ctl %b addr %h required 101001111 / 100", {ba.if_gnt_o,
               ba.d_gnt_o, ba.mem_en_o, ba.mem_we_o, ba.busy_o, ba.mem_be_o}, ba.mem_addr_o);
    end
    nxt(); ba.if_req_i = 0; #3;
    n_chk++;
    if ({ba.if_gnt_o, ba.mem_en_o, ba.busy_o, ba.if_rvalid_o} !== 4'b0010
        || ba.mem_addr_o !== '0 || ba.mem_be_o !== '0) begin
      n_fail++;
      $display("FAIL fetch_wait1: gnt/en/busy/rv %b addr %h be %b required 0010/0/0",
               {ba.if_gnt_o, ba.mem_en_o, ba.busy_o, ba.if_rvalid_o}, ba.mem_addr_o, ba.mem_be_o);
    end
    nxt(); ba.mem_rdata_i = 32'hDEAD_BEEF; #3;
    n_chk++;
    if ({ba.busy_o, ba.if_rvalid_o} !== 2'b10) begin
      n_fail++; $display("FAIL fetch_wait2: busy/rv %b required 10", {ba.busy_o, ba.if_rvalid_o});
    end
    nxt(); ba.mem_rdata_i = 32'h0BAD_F00D; #3;
    n_chk++;
    if ({ba.if_rvalid_o, ba.d_rvalid_o, ba.busy_o} !== 3'b101 || ba.if_rdata_o !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL fetch_resp: rv/drv/busy %b data %h required 101 / deadbeef",
               {ba.if_rvalid_o, ba.d_rvalid_o, ba.busy_o}, ba.if_rdata_o);
    end
    nxt(); #3;
    n_chk++;
    if ({ba.if_rvalid_o, ba.busy_o} !== 2'b00) begin
      n_fail++; $display("FAIL fetch_idle: rv/busy %b required 00", {ba.if_rvalid_o, ba.busy_o});
    end
  endtask

  task automatic test_priority();
    nxt(); ba.if_req_i = 1; ba.if_addr_i = 32'h104; ba.d_req_i = 1; ba.d_we_i = 0;
    ba.d_addr_i = 32'h200; #3;
    n_chk++;
    if ({ba.if_gnt_o, ba.d_gnt_o} !== 2'b01 || ba.mem_addr_o !== 32'h200 || ba.mem_be_o !== 4'hF) begin
      n_fail++;
      $display("FAIL prio_first: gnt %b addr %h be %b required 01/200/1111",
               {ba.if_gnt_o, ba.d_gnt_o}, ba.mem_addr_o, ba.mem_be_o);
    end
    nxt(); ba.d_req_i = 0; #3;
    n_chk++;
    if ({ba.if_gnt_o, ba.d_gnt_o} !== 2'b00) begin
      n_fail++; $display("FAIL prio_stall: gnt %b required 00", {ba.if_gnt_o, ba.d_gnt_o});
    end
    nxt(); ba.mem_rdata_i = 32'hCAFE_F00D; #3;
    nxt(); ba.mem_rdata_i = 32'h1111_2222; #3;
    n_chk++;
    if ({ba.d_rvalid_o, ba.if_gnt_o, ba.d_gnt_o} !== 3'b110 || ba.d_rdata_o !== 32'hCAFE_F00D
        || ba.mem_addr_o !== 32'h104) begin
      n_fail++;
      $display("FAIL prio_resp: drv/ign/dgn %b data %h addr %h required 110/cafef00d/104",
               {ba.d_rvalid_o, ba.if_gnt_o, ba.d_gnt_o}, ba.d_rdata_o, ba.mem_addr_o);
    end
    nxt(); ba.if_req_i = 0;
    nxt(); ba.mem_rdata_i = 32'h600D_F00D;
    nxt(); #3;
    n_chk++;
    if ({ba.if_rvalid_o, ba.d_rvalid_o} !== 2'b10 || ba.if_rdata_o !== 32'h600D_F00D) begin
      n_fail++;
      $display("FAIL prio_fetch_resp: rv %b data %h required 10/600df00d",
               {ba.if_rvalid_o, ba.d_rvalid_o}, ba.if_rdata_o);
    end
  endtask

  task automatic test_store();
    nxt(); ba.d_req_i = 1; ba.d_we_i = 1; ba.d_addr_i = 32'h300; ba.d_wdata_i = 32'h1234_5678;
    ba.d_be_i = 4'b0011; #3;
    n_chk++;
    if ({ba.d_gnt_o, ba.mem_en_o, ba.mem_we_o, ba.mem_be_o} !== 7'b111_0011
        || ba.mem_wdata_o !== 32'h1234_5678 || ba.mem_addr_o !== 32'h300) begin
      n_fail++;
      $display("FAIL store_issue: ctl %b wdata %h addr %h required 1110011/12345678/300",
               {ba.d_gnt_o, ba.mem_en_o, ba.mem_we_o, ba.mem_be_o}, ba.mem_wdata_o, ba.mem_addr_o);
    end
    nxt(); ba.d_req_i = 0; ba.d_we_i = 0; #3;
    n_chk++;
    if ({ba.mem_en_o, ba.mem_we_o, ba.mem_be_o, ba.mem_addr_o, ba.mem_wdata_o} !== '0) begin
      n_fail++;
      $display("FAIL store_quiet: en %b we %b be %b addr %h wdata %h required all 0", ba.mem_en_o,
               ba.mem_we_o, ba.mem_be_o, ba.mem_addr_o, ba.mem_wdata_o);
    end
    nxt(); ba.mem_rdata_i = 32'hFFFF_FFFF;
    nxt(); #3;
    n_chk++;
    if (ba.d_rvalid_o !== 1'b1 || ba.d_rdata_o !== '0) begin
      n_fail++;
      $display("FAIL store_done: drv %b data %h required 1/0", ba.d_rvalid_o, ba.d_rdata_o);
    end
    nxt();
  endtask

  task automatic test_starve();
    int seen = 0;
    bit exp_f;
    nxt(); ba.if_req_i = 1; ba.d_req_i = 1; ba.d_we_i = 0;
    for (int c = 0; c < 40 && seen < 10; c++) begin
      if (c > 0) nxt();
      ba.mem_rdata_i = $urandom | 32'h1;
      #3;
      if (ba.if_gnt_o || ba.d_gnt_o) begin
        exp_f = (seen % 5 == 4);
        n_chk++;
        if ({ba.if_gnt_o, ba.d_gnt_o} !== (exp_f ? 2'b10 : 2'b01) || c !== seen * (LAT + 1)) begin
          n_fail++;
          $display("FAIL starve_seq: grant #%0d at cycle %0d gnt %b required cycle %0d gnt %b",
                   seen, c, {ba.if_gnt_o, ba.d_gnt_o}, seen * (LAT + 1), exp_f ? 2'b10 : 2'b01);
        end
        seen++;
      end
    end
    n_chk++;
    if (seen != 10) begin
      n_fail++; $display("FAIL starve_count: saw %0d grants required 10", seen);
    end
    nxt(); ba.if_req_i = 0; ba.d_req_i = 0;
    repeat (4) nxt();
  endtask

  task automatic test_reset_wait();
    nxt(); ba.d_req_i = 1; ba.d_we_i = 0; ba.d_addr_i = 32'h400; #3;
    n_chk++;
    if (ba.d_gnt_o !== 1'b1) begin
      n_fail++; $display("FAIL rstw_grant: d_gnt %b required 1", ba.d_gnt_o);
    end
    nxt(); ba.d_req_i = 0; #1; rst = 0; #1;
    n_chk++;
    if ({ba.busy_o, ba.mem_en_o, ba.d_rvalid_o, ba.if_rvalid_o, ba.d_rdata_o, ba.if_rdata_o} !== '0) begin
      n_fail++;
      $display("FAIL rstw_async: busy/en/rv %b d_rdata %h if_rdata %h required 0",
               {ba.busy_o, ba.mem_en_o, ba.d_rvalid_o, ba.if_rvalid_o}, ba.d_rdata_o, ba.if_rdata_o);
    end
    nxt(); rst = 1;
    for (int i = 0; i < 6; i++) begin
      nxt(); ba.mem_rdata_i = $urandom; #3;
      n_chk++;
      if ({ba.d_rvalid_o, ba.busy_o} !== 2'b00) begin
        n_fail++; $display("FAIL rstw_ghost: cycle %0d rv/busy %b required 00", i, {ba.d_rvalid_o, ba.busy_o});
      end
    end
    nxt(); ba.if_req_i = 1; ba.if_addr_i = 32'h500; #3;
    n_chk++;
    if (ba.if_gnt_o !== 1'b1 || ba.mem_addr_o !== 32'h500) begin
      n_fail++; $display("FAIL rstw_regrant: gnt %b addr %h required 1/500", ba.if_gnt_o, ba.mem_addr_o);
    end
    nxt(); ba.if_req_i = 0;
    nxt(); ba.mem_rdata_i = 32'h5A5A_1234;
    nxt(); #3;
    n_chk++;
    if (ba.if_rvalid_o !== 1'b1 || ba.if_rdata_o !== 32'h5A5A_1234) begin
      n_fail++; $display("FAIL rstw_resp: rv %b data %h required 1/5a5a1234", ba.if_rvalid_o, ba.if_rdata_o);
    end
    nxt();
  endtask

  // MEM_LAT=1 with fetch held high: grant on even cycles, rvalid two cycles
  // after each grant carrying the memory word presented one cycle after it.
  task automatic test_lat1();
    logic [DW-1:0] md [0:31];
    bit eg, erv;
    for (int c = 0; c < 32; c++) begin
      nxt();
      bb.if_req_i = 1; bb.if_addr_i = 32'(c * 4); bb.mem_rdata_i = $urandom; md[c] = bb.mem_rdata_i;
      #3;
      eg  = (c % 2 == 0);
      erv = (c >= 2) && (c % 2 == 0);
      n_chk++;
      if (bb.if_gnt_o !== eg || bb.if_rvalid_o !== erv || (eg && bb.mem_addr_o !== 32'(c * 4))) begin
        n_fail++;
        $display("FAIL lat1_timing: cycle %0d gnt %b rv %b addr %h required %b %b %h", c,
                 bb.if_gnt_o, bb.if_rvalid_o, bb.mem_addr_o, eg, erv, 32'(c * 4));
      end
      if (erv) begin
        n_chk++;
        if (bb.if_rdata_o !== md[c-1]) begin
          n_fail++; $display("FAIL lat1_data: cycle %0d got %h required %h", c, bb.if_rdata_o, md[c-1]);
        end
      end
    end
    nxt(); bb.if_req_i = 0;
    repeat (3) nxt();
  endtask

  // Model: a transaction granted at cycle g owns the port until its response
  // at g+LAT+1; memory data sampled at g+LAT is what that response returns.
  task automatic test_random();
    int g = -100, st = 0;
    bit gd = 0, gs = 0, clr_f = 0, clr_d = 0;
    logic [DW-1:0] cap = '0;
    bit fw, dw, ea, rv, ebusy;
    logic e_we;
    logic [3:0] e_be;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd, e_rd;
    for (int k = 0; k < 400; k++) begin
      nxt();
      if (clr_f) ba.if_req_i = 0;
      if (clr_d) ba.d_req_i = 0;
      clr_f = 0; clr_d = 0;
      if (!ba.if_req_i) begin
        if ($urandom_range(2) == 0) begin ba.if_req_i = 1; ba.if_addr_i = $urandom; end
      end else if ($urandom_range(9) == 0) ba.if_req_i = 0;
      if (!ba.d_req_i) begin
        if ($urandom_range(1) == 0) begin
          ba.d_req_i = 1; ba.d_we_i = $urandom_range(1); ba.d_addr_i = $urandom;
          ba.d_wdata_i = $urandom; ba.d_be_i = 4'($urandom);
        end
      end else if ($urandom_range(9) == 0) ba.d_req_i = 0;
      ba.mem_rdata_i = $urandom;
      #3;
      ea     = (k >= g + LAT + 1);
      fw     = ea && ba.if_req_i && (!ba.d_req_i || st == SM);
      dw     = ea && ba.d_req_i && !fw;
      e_we   = dw && ba.d_we_i;
      e_be   = e_we ? ba.d_be_i : (fw || dw) ? 4'hF : 4'h0;
      e_addr = dw ? ba.d_addr_i : fw ? ba.if_addr_i : '0;
      e_wd   = e_we ? ba.d_wdata_i : '0;
      rv     = (k == g + LAT + 1);
      ebusy  = (k >= g + 1) && (k <= g + LAT + 1);
      n_chk++;
      if ({ba.if_gnt_o, ba.d_gnt_o, ba.mem_en_o, ba.busy_o} !== {fw, dw, fw || dw, ebusy}) begin
        n_fail++;
        $display("FAIL rand_ctl: cycle %0d gnt/en/busy %b required %b", k,
                 {ba.if_gnt_o, ba.d_gnt_o, ba.mem_en_o, ba.busy_o}, {fw, dw, fw || dw, ebusy});
      end
      n_chk++;
      if ({ba.mem_we_o, ba.mem_be_o, ba.mem_addr_o, ba.mem_wdata_o} !== {e_we, e_be, e_addr, e_wd}) begin
        n_fail++;
        $display("FAIL rand_mem: cycle %0d we %b be %b addr %h wdata %h required %b %b %h %h", k,
                 ba.mem_we_o, ba.mem_be_o, ba.mem_addr_o, ba.mem_wdata_o, e_we, e_be, e_addr, e_wd);
      end
      n_chk++;
      if ({ba.if_rvalid_o, ba.d_rvalid_o} !== {rv && !gd, rv && gd}) begin
        n_fail++;
        $display("FAIL rand_rvalid: cycle %0d got %b required %b", k,
                 {ba.if_rvalid_o, ba.d_rvalid_o}, {rv && !gd, rv && gd});
      end
      if (rv) begin
        e_rd = (gd && gs) ? '0 : cap;
        n_chk++;
        if ((gd ? ba.d_rdata_o : ba.if_rdata_o) !== e_rd) begin
          n_fail++;
          $display("FAIL rand_rdata: cycle %0d port %s got %h required %h", k, gd ? "d" : "if",
                   gd ? ba.d_rdata_o : ba.if_rdata_o, e_rd);
        end
      end
      if (k == g + LAT) cap = ba.mem_rdata_i;
      if (!ba.if_req_i || fw) st = 0;
      else if (dw && st < SM) st++;
      if (fw || dw) begin
        g = k; gd = dw; gs = dw && ba.d_we_i;
        if (fw) clr_f = 1; else clr_d = 1;
      end
    end
    nxt(); ba.if_req_i = 0; ba.d_req_i = 0;
    repeat (4) nxt();
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_priority();
    test_store();
    test_starve();
    test_reset_wait();
    test_lat1();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port unified memory between the instruction-fetch port and the load/store (data) port of the RISC-V core.
- Sits between the fetch stage and memory on one side, and between the load/store stage and memory on the other.
- Grants one transaction at a time, sequences the fixed memory latency and returns read data/completion to the winning requester.
- Data port has priority. A starvation guard forces a fetch grant after a bounded run of data grants.

Parameters:
AW, 32, address width
DW, 32, data width (byte enables = DW/8)
MEM_LAT, 2, cycles from mem_en_o to valid mem_rdata_i; must be >=1 (elaboration error otherwise)
STARVE_MAX, 4, max consecutive data grants while fetch is pending

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-low
if_req_i  in  1  fetch request; held with address until granted
if_addr_i  in  AW  fetch address
if_gnt_o  out  1  fetch grant pulse
if_rvalid_o  out  1  fetch read data valid pulse
if_rdata_o  out  DW  fetch read data
d_req_i  in  1  data request; held with fields until granted
d_we_i  in  1  1=store, 0=load
d_addr_i  in  AW  data address
d_wdata_i  in  DW  store data
d_be_i  in  DW/8  store byte enables
d_gnt_o  out  1  data grant pulse
d_rvalid_o  out  1  load data valid or store completion pulse
d_rdata_o  out  DW  load data (0 on store completion)
mem_en_o  out  1  memory access strobe
mem_we_o  out  1  memory write
mem_be_o  out  DW/8  memory byte enables
mem_addr_o  out  AW  memory address
mem_wdata_o  out  DW  memory write data
mem_rdata_i  in  DW  memory read data, valid MEM_LAT cycles after mem_en_o
busy_o  out  1  transaction outstanding (state != IDLE)

Behaviour:
- **FSM states:** IDLE, WAIT, RESP.
- **Arbitration:** happens in IDLE and RESP only.
- **Grant:** a grant is combinational in the arbitration cycle: gnt_o=1, mem_en_o=1, and mem_* driven from the winner. The FSM then moves to WAIT with cnt=MEM_LAT-1.
- **WAIT:** lasts MEM_LAT cycles. On its last cycle (cnt==0), mem_rdata_i is registered into the winner's rdata_o, and the FSM moves to RESP.
- **RESP:** winner's rvalid_o=1 for exactly one cycle.
  - If no request is pending, go to IDLE.
  - Otherwise issue the next grant in the same cycle.
- **Timing:** issue at cycle t gives rvalid at t+MEM_LAT+1. Maximum throughput is one transaction per MEM_LAT+1 cycles. Only one transaction is ever outstanding.
- **Fetch accesses:** mem_we_o=0, mem_be_o=all ones.
- **Loads:** mem_we_o=0, mem_be_o=all ones.
- **Stores:** mem_we_o=1, mem_be_o=d_be_i, mem_wdata_o=d_wdata_i. Completion is d_rvalid_o with d_rdata_o=0.
- **mem_* outputs when mem_en_o=0:** mem_we_o=0 and mem_be_o=0; addr/wdata hold 0.
- **Priority:** data beats fetch unless starve_cnt==STARVE_MAX, in which case fetch wins.
- **starve_cnt:**
  - increments on each data grant while if_req_i=1
  - clears on any fetch grant, or when if_req_i=0
  - saturates at STARVE_MAX
- **Requester rules:**
  - A requester may drop req before its grant with no effect.
  - Requests arriving in WAIT are stalled (no gnt) until RESP.
- **Reset (rst=0, asynchronous):**
  - state=IDLE, cnt=0, starve_cnt=0
  - all gnt/rvalid/busy/mem_en/mem_we low; rdata_o=0
  - An outstanding transaction is dropped: no rvalid is ever produced for it.
- **Grant-output reset values:** outputs derived from grant are 0 during reset regardless of requests.
- **Wrap/corners:**
  - MEM_LAT=1: WAIT is a single cycle.
  - A requester that is granted in RESP may also be the one receiving rvalid that cycle (back-to-back same port).

Test Plan:
- MEM_LAT=2, single fetch at addr 0x100, mem returns 0xDEADBEEF -> if_gnt_o at t, if_rvalid_o at t+3 with if_rdata_o=0xDEADBEEF, busy_o high t+1..t+3.
- Simultaneous if_req_i and d_req_i (load 0x200) in IDLE -> d_gnt_o first; if_gnt_o in the RESP cycle of the load (t+3); d_rvalid_o and if_gnt_o coincide.
- Store 0x300, data 0x12345678, be 4'b0011 -> mem_we_o=1, mem_be_o=0011, mem_wdata_o=0x12345678 for one cycle; d_rvalid_o at t+3 with d_rdata_o=0.
- STARVE_MAX=4, d_req_i and if_req_i held high continuously -> grant sequence D,D,D,D,F,D,D,D,D,F...
- rst asserted during WAIT of a load -> all outputs 0 immediately (async); after release no d_rvalid_o for the aborted load; next request granted from IDLE.
- MEM_LAT=1, back-to-back fetches -> one if_gnt_o every 2 cycles, each rvalid 2 cycles after its grant, data matching mem_rdata_i.
